stream_mux_arb: RTL and testbench

//   Registered, parametrised N:1 stream multiplexer. It is the sequential successor of the 8:1 dataflow mux.
//   It selects one of N_CH valid/ready input channels by fixed select, fixed priority or round-robin arbitration.
//   A grant is held for a whole packet, up to and including the in_last beat.

---
 rtl/stream_mux_pkg.sv | 7 +
 rtl/stream_mux_arb_rr_arbiter.sv | 25 ++
 rtl/stream_mux_arb.sv | 87 ++++++++
 tb/tb_stream_mux_arb.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: mode and FSM state encodings shared by the stream mux arbiter
package stream_mux_pkg;
  localparam logic [1:0] MODE_FIXED = 2'b00;
  localparam logic [1:0] MODE_PRIO  = 2'b01;
  localparam logic [1:0] MODE_RR    = 2'b10;
  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;
endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// rr_arbiter: combinational search for the first request after ptr, wrapping mod N_CH
module rr_arbiter #(
  parameter int N_CH  = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);
  int k;
  // scan from farthest to nearest so the nearest request after ptr wins
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    k = 0;
    for (int i = N_CH; i >= 1; i--) begin
      k = (int'(ptr) + i) % N_CH;
      if (req[k]) begin
        gnt_vld = 1'b1;
        gnt_idx = SEL_W'(k);
      end
    end
  end
endmodule

// File: rtl/stream_mux_arb.sv
// stream_mux_arb: registered N:1 stream mux with fixed/priority/round-robin packet arbitration
module stream_mux_arb
  import stream_mux_pkg::*;
#(
  parameter int N_CH   = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic [SEL_W-1:0]       sel_fixed,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH-1:0]        in_last,
  input  logic [N_CH*DATA_W-1:0] in_data,
  output logic [N_CH-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  output logic [SEL_W-1:0]       out_ch,
  input  logic                   out_ready
);
  state_t            st_q;
  logic [SEL_W-1:0]  lock_ch_q, rr_ptr_q, out_ch_q, gnt, prio_idx, rr_idx;
  logic [DATA_W-1:0] out_data_q, data_g;
  logic              out_valid_q, out_last_q, load_en, locked, gnt_vld, fix_vld;
  logic              prio_vld, rr_vld, xfer, last_g;
  logic [N_CH-1:0]   fix_hot;

  rr_arbiter #(.N_CH(N_CH), .SEL_W(SEL_W)) u_prio (
    .req(in_valid), .ptr(SEL_W'(N_CH - 1)), .gnt_idx(prio_idx), .gnt_vld(prio_vld)
  );
  rr_arbiter #(.N_CH(N_CH), .SEL_W(SEL_W)) u_rr (
    .req(in_valid), .ptr(rr_ptr_q), .gnt_idx(rr_idx), .gnt_vld(rr_vld)
  );

  // out-of-range sel_fixed shifts out of the vector and yields no grant
  assign fix_hot = N_CH'(1) << sel_fixed;
  assign fix_vld = |(in_valid & fix_hot);
  assign load_en = ~out_valid_q | out_ready;
  assign locked  = st_q == ST_LOCKED;
  assign gnt     = locked ? lock_ch_q :
                   mode == MODE_FIXED ? sel_fixed :
                   mode == MODE_PRIO  ? prio_idx : rr_idx;
  assign gnt_vld = locked | (mode == MODE_FIXED ? fix_vld :
                             mode == MODE_PRIO  ? prio_vld :
                             mode == MODE_RR    ? rr_vld : 1'b0);
  assign in_ready = (load_en && gnt_vld) ? N_CH'(1) << gnt : '0;
  assign xfer     = |(in_valid & in_ready);
  assign last_g   = |(in_last & in_ready);

  always_comb begin
    data_g = '0;
    for (int i = 0; i < N_CH; i++)
      if (in_ready[i]) data_g = in_data[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= ST_IDLE;
      lock_ch_q   <= '0;
      rr_ptr_q    <= SEL_W'(N_CH - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      if (load_en) out_valid_q <= xfer;
      if (xfer) begin
        out_data_q <= data_g;
        out_last_q <= last_g;
        out_ch_q   <= gnt;
        if (!locked && !last_g) begin
          st_q      <= ST_LOCKED;
          lock_ch_q <= gnt;
        end
        if (locked && last_g) st_q <= ST_IDLE;
        if (last_g) rr_ptr_q <= gnt;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;
endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb: directed checks of the stream mux arbiter (8-channel and 6-channel instances)
module tb_stream_mux_arb;
  logic        clk = 1'b0, rst_n = 1'b0, out_ready = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic [2:0]  sel_fixed = 3'd0;
  logic [7:0]  in_valid = '0, in_last = '0, in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid, out_last;
  logic [7:0]  out_data;
  logic [2:0]  out_ch;
  logic [2:0]  sel6 = 3'd7;
  logic [5:0]  in_ready6;
  logic        out_valid6, out_last6;
  logic [7:0]  out_data6;
  logic [2:0]  out_ch6;
  int          total = 0, bad = 0;
  int          rr_exp [5] = '{0, 2, 5, 7, 0};

  always #5 clk = ~clk;

  stream_mux_arb #(.N_CH(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel_fixed(sel_fixed),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  stream_mux_arb #(.N_CH(6), .DATA_W(8)) dut6 (
    .clk(clk), .rst_n(rst_n), .mode(2'b00), .sel_fixed(sel6),
    .in_valid(6'h3F), .in_last(6'h3F), .in_data(48'h151413121110), .in_ready(in_ready6),
    .out_valid(out_valid6), .out_data(out_data6), .out_last(out_last6), .out_ch(out_ch6),
    .out_ready(1'b1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic [2:0] ch, input logic l);
    chk({tag, "_v"}, 32'(out_valid), 32'd1);
    chk({tag, "_d"}, 32'(out_data), 32'(d));
    chk({tag, "_ch"}, 32'(out_ch), 32'(ch));
    chk({tag, "_l"}, 32'(out_last), 32'(l));
  endtask

  initial begin
    for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'h10 + 8'(k);
    #3;
    chk("rst_v", 32'(out_valid), 0);
    chk("rst_d", 32'(out_data), 0);
    chk("rst_ch", 32'(out_ch), 0);
    chk("rst_l", 32'(out_last), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    // fixed select
    mode = 2'b00; sel_fixed = 3'd2; in_valid = 8'hFF; in_last = 8'hFF;
    #1 chk("fix_rdy2", 32'(in_ready), 32'h04);
    cyc();
    chk_out("fix2", 8'h12, 3'd2, 1'b1);
    sel_fixed = 3'd7;
    #1 chk("fix_rdy7", 32'(in_ready), 32'h80);
    cyc();
    chk_out("fix7", 8'h17, 3'd7, 1'b1);
    // round robin, one beat per cycle
    mode = 2'b10; in_valid = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_out($sformatf("rr%0d", i), 8'h10 + 8'(rr_exp[i]), 3'(rr_exp[i]), 1'b1);
    end
    // packet lock on ch3 in priority mode
    mode = 2'b01; in_valid = '0;
    cyc();
    chk("lk_idle_v", 32'(out_valid), 0);
    in_valid = 8'h08; in_last = '0; in_data[24 +: 8] = 8'hA1;
    cyc();
    chk_out("lk1", 8'hA1, 3'd3, 1'b0);
    in_valid = 8'h01; in_last = 8'h01;
    #1 chk("lk_hold_rdy", 32'(in_ready), 32'h08);
    cyc();
    chk("lk_gap_v", 32'(out_valid), 0);
    in_valid = 8'h09; in_last = 8'h01; in_data[24 +: 8] = 8'hA2; mode = 2'b00; sel_fixed = 3'd0;
    #1 chk("lk_rdy2", 32'(in_ready), 32'h08);
    cyc();
    chk_out("lk2", 8'hA2, 3'd3, 1'b0);
    in_data[24 +: 8] = 8'hA3; in_last = 8'h09; mode = 2'b01;
    cyc();
    chk_out("lk3", 8'hA3, 3'd3, 1'b1);
    in_valid = 8'h01;
    #1 chk("lk_ch0_rdy", 32'(in_ready), 32'h01);
    cyc();
    chk_out("lk_ch0", 8'h10, 3'd0, 1'b1);
    // backpressure
    out_ready = 1'b0; in_data[7:0] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      #1 chk($sformatf("bp_rdy%0d", i), 32'(in_ready), 0);
      cyc();
      chk_out($sformatf("bp%0d", i), 8'h10, 3'd0, 1'b1);
    end
    out_ready = 1'b1;
    #1 chk("bp_rel_rdy", 32'(in_ready), 32'h01);
    cyc();
    chk_out("bp_rel", 8'h55, 3'd0, 1'b1);
    in_valid = '0;
    cyc();
    chk("bp_nodup_v", 32'(out_valid), 0);
    // mode 11 and out-of-range sel
    mode = 2'b11; in_valid = 8'hFF; in_last = 8'hFF;
    #1 chk("m11_rdy", 32'(in_ready), 0);
    chk("oor_rdy", 32'(in_ready6), 0);
    cyc();
    chk("m11_v", 32'(out_valid), 0);
    chk("oor_v", 32'(out_valid6), 0);
    sel6 = 3'd5;
    #1 chk("n6_rdy5", 32'(in_ready6), 32'h20);
    cyc();
    chk("n6_ch", 32'(out_ch6), 5);
    chk("n6_d", 32'(out_data6), 32'h15);
    // reset mid-packet
    mode = 2'b10; in_valid = 8'h02; in_last = '0; in_data[15:8] = 8'hB1;
    cyc();
    chk_out("rm1", 8'hB1, 3'd1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rm_v", 32'(out_valid), 0);
    chk("rm_d", 32'(out_data), 0);
    chk("rm_ch", 32'(out_ch), 0);
    chk("rm_l", 32'(out_last), 0);
    in_valid = 8'h03; in_last = 8'hFF;
    #2 rst_n = 1'b1;
    #1 chk("rm_rr_rdy", 32'(in_ready), 32'h01);
    cyc();
    chk_out("rm_rr", 8'h55, 3'd0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
